// File: rtl/regfile_scoreboard.sv
// Register file with hardwired zero, optional write-to-read bypass and
// per-register busy scoreboard for in-flight results.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   WR, WReg, WDATA   synchronous write port (also clears busy[WReg])
//   RReg1/2, RD1/2    combinational read ports
//   MARK, MReg        set busy[MReg] at the edge (wins over a clear)
//   BUSY1/2           busy bit of RReg1/2, ANY_BUSY is OR of all busy bits
module regfile_scoreboard #(
   parameter int N        = 32,
   parameter int AW       = 5,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          WR,
   input  logic [AW-1:0] WReg,
   input  logic [N-1:0]  WDATA,
   input  logic [AW-1:0] RReg1,
   input  logic [AW-1:0] RReg2,
   output logic [N-1:0]  RD1,
   output logic [N-1:0]  RD2,
   input  logic          MARK,
   input  logic [AW-1:0] MReg,
   output logic          BUSY1,
   output logic          BUSY2,
   output logic          ANY_BUSY
);

   localparam int DEPTH = 1 << AW;
   localparam bit ZR    = (ZERO_REG != 0);
   localparam bit BP    = (BYPASS != 0);

   logic [N-1:0]     regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;
   logic             we;
   logic             mk;

   // Effective write/mark: register 0 is immune when hardwired to zero.
   assign we = rst && WR && !(ZR && (WReg == '0));
   assign mk = MARK && !(ZR && (MReg == '0));

   // The mark belongs to a newer producer, so it is applied after the clear.
   always_comb begin
      busy_nxt = busy;
      if (we) busy_nxt[WReg] = 1'b0;
      if (mk) busy_nxt[MReg] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (we) regs[WReg] <= WDATA;
         busy <= busy_nxt;
      end
   end

   always_comb begin
      RD1 = regs[RReg1];
      if (BP && we && (WReg == RReg1)) RD1 = WDATA;
      if (ZR && (RReg1 == '0)) RD1 = '0;
   end

   always_comb begin
      RD2 = regs[RReg2];
      if (BP && we && (WReg == RReg2)) RD2 = WDATA;
      if (ZR && (RReg2 == '0)) RD2 = '0;
   end

   // No bypass on busy: a clearing write shows only after the edge.
   assign BUSY1    = busy[RReg1] && !(ZR && (RReg1 == '0));
   assign BUSY2    = busy[RReg2] && !(ZR && (RReg2 == '0));
   assign ANY_BUSY = |busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: three 32x32 configurations driven
// in parallel plus a 16-bit, 8-entry instance.
module tb_regfile_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   logic        rst = 1'b0;
   logic        wr = 1'b0;
   logic [4:0]  wreg = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  rreg1 = '0;
   logic [4:0]  rreg2 = '0;
   logic        mark = 1'b0;
   logic [4:0]  mreg = '0;

   // index 0: bypass+zero, 1: no bypass+zero, 2: bypass, no zero reg
   logic [31:0] rd1 [3];
   logic [31:0] rd2 [3];
   logic        b1 [3];
   logic        b2 [3];
   logic        ab [3];

   regfile_scoreboard #(.BYPASS(1), .ZERO_REG(1)) u_a (
      .clk(clk), .rst(rst), .WR(wr), .WReg(wreg), .WDATA(wdata),
      .RReg1(rreg1), .RReg2(rreg2), .RD1(rd1[0]), .RD2(rd2[0]),
      .MARK(mark), .MReg(mreg), .BUSY1(b1[0]), .BUSY2(b2[0]),
      .ANY_BUSY(ab[0]));

   regfile_scoreboard #(.BYPASS(0), .ZERO_REG(1)) u_b (
      .clk(clk), .rst(rst), .WR(wr), .WReg(wreg), .WDATA(wdata),
      .RReg1(rreg1), .RReg2(rreg2), .RD1(rd1[1]), .RD2(rd2[1]),
      .MARK(mark), .MReg(mreg), .BUSY1(b1[1]), .BUSY2(b2[1]),
      .ANY_BUSY(ab[1]));

   regfile_scoreboard #(.BYPASS(1), .ZERO_REG(0)) u_c (
      .clk(clk), .rst(rst), .WR(wr), .WReg(wreg), .WDATA(wdata),
      .RReg1(rreg1), .RReg2(rreg2), .RD1(rd1[2]), .RD2(rd2[2]),
      .MARK(mark), .MReg(mreg), .BUSY1(b1[2]), .BUSY2(b2[2]),
      .ANY_BUSY(ab[2]));

   logic        s_wr = 1'b0;
   logic [2:0]  s_wreg = '0;
   logic [15:0] s_wdata = '0;
   logic [2:0]  s_r1 = '0;
   logic [2:0]  s_r2 = '0;
   logic        s_mark = 1'b0;
   logic [2:0]  s_mreg = '0;
   logic [15:0] s_rd1, s_rd2;
   logic        s_b1, s_b2, s_ab;

   regfile_scoreboard #(.N(16), .AW(3)) u_s (
      .clk(clk), .rst(rst), .WR(s_wr), .WReg(s_wreg), .WDATA(s_wdata),
      .RReg1(s_r1), .RReg2(s_r2), .RD1(s_rd1), .RD2(s_rd2),
      .MARK(s_mark), .MReg(s_mreg), .BUSY1(s_b1), .BUSY2(s_b2),
      .ANY_BUSY(s_ab));

   // Reference model for the three 32x32 instances.
   logic [31:0] m_regs [3][32];
   bit          m_busy [3][32];

   function automatic bit byp(int k);
      return k != 1;
   endfunction

   function automatic bit zr(int k);
      return k != 2;
   endfunction

   function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
      if (zr(k) && a == 0) return 32'h0;
      if (byp(k) && rst && wr && wreg == a && !(zr(k) && wreg == 0))
         return wdata;
      return m_regs[k][a];
   endfunction

   function automatic bit exp_any(int k);
      for (int i = 0; i < 32; i++) if (m_busy[k][i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         if (!rst) begin
            for (int i = 0; i < 32; i++) begin
               m_regs[k][i] = 32'h0;
               m_busy[k][i] = 1'b0;
            end
         end else begin
            if (wr && !(zr(k) && wreg == 0)) begin
               m_regs[k][wreg] = wdata;
               m_busy[k][wreg] = 1'b0;
            end
            if (mark && !(zr(k) && mreg == 0)) m_busy[k][mreg] = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr = 1'b0; mark = 1'b0; s_wr = 1'b0; s_mark = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rreg1 = 5'd7; rreg2 = 5'd9;
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (rd1[k] !== 32'h0 || b2[k] !== 1'b0 || ab[k] !== 1'b0)
            $display("FAIL reset_init[%0d] rd1=%h b2=%b ab=%b want 0",
                     k, rd1[k], b2[k], ab[k]);
         else passed++;
      end
      wr = 1'b1; wreg = 5'd7; wdata = 32'h12345678;
      mark = 1'b1; mreg = 5'd9;
      step();
      idle();
      #1;
      total++;
      if (rd1[0] !== 32'h12345678 || b2[0] !== 1'b1 || ab[0] !== 1'b1)
         $display("FAIL reset_pre rd1=%h b2=%b ab=%b want 12345678/1/1",
                  rd1[0], b2[0], ab[0]);
      else passed++;
      // reset coincident with write and mark: reset wins
      rst = 1'b0;
      wr = 1'b1; wreg = 5'd7; wdata = 32'hFFFFFFFF;
      mark = 1'b1; mreg = 5'd9;
      step();
      idle();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (rd1[k] !== 32'h0 || b2[k] !== 1'b0 || ab[k] !== 1'b0)
            $display("FAIL reset_clear[%0d] rd1=%h b2=%b ab=%b want 0",
                     k, rd1[k], b2[k], ab[k]);
         else passed++;
      end
   endtask

   task automatic test_bypass();
      do_reset();
      wr = 1'b1; wreg = 5'd5; wdata = 32'hDEADBEEF;
      rreg1 = 5'd5; rreg2 = 5'd5;
      #1;
      total++;
      if (rd1[0] !== 32'hDEADBEEF || rd2[0] !== 32'hDEADBEEF)
         $display("FAIL bypass_on rd1=%h rd2=%h want deadbeef",
                  rd1[0], rd2[0]);
      else passed++;
      total++;
      if (rd1[1] !== 32'h0)
         $display("FAIL bypass_off_pre rd1=%h want 0", rd1[1]);
      else passed++;
      step();
      idle();
      #1;
      total++;
      if (rd1[1] !== 32'hDEADBEEF)
         $display("FAIL bypass_off_post rd1=%h want deadbeef", rd1[1]);
      else passed++;
   endtask

   task automatic test_zero_reg();
      do_reset();
      wr = 1'b1; wreg = 5'd0; wdata = 32'hCAFEBABE;
      mark = 1'b1; mreg = 5'd0;
      rreg1 = 5'd0;
      #1;
      total++;
      if (rd1[0] !== 32'h0 || b1[0] !== 1'b0)
         $display("FAIL zero_pre rd1=%h b1=%b want 0/0", rd1[0], b1[0]);
      else passed++;
      total++;
      if (rd1[2] !== 32'hCAFEBABE)
         $display("FAIL zero_off_pre rd1=%h want cafebabe", rd1[2]);
      else passed++;
      step();
      idle();
      #1;
      total++;
      if (rd1[0] !== 32'h0 || b1[0] !== 1'b0 || ab[0] !== 1'b0)
         $display("FAIL zero_post rd1=%h b1=%b ab=%b want 0/0/0",
                  rd1[0], b1[0], ab[0]);
      else passed++;
      total++;
      if (rd1[2] !== 32'hCAFEBABE || b1[2] !== 1'b1)
         $display("FAIL zero_off_post rd1=%h b1=%b want cafebabe/1",
                  rd1[2], b1[2]);
      else passed++;
   endtask

   task automatic test_scoreboard();
      do_reset();
      mark = 1'b1; mreg = 5'd10; rreg2 = 5'd10;
      step();
      idle();
      #1;
      total++;
      if (b2[0] !== 1'b1 || ab[0] !== 1'b1)
         $display("FAIL sb_mark b2=%b ab=%b want 1/1", b2[0], ab[0]);
      else passed++;
      wr = 1'b1; wreg = 5'd10; wdata = 32'hA5A5A5A5;
      #1;
      total++;
      if (b2[0] !== 1'b1)
         $display("FAIL sb_no_bypass b2=%b want 1", b2[0]);
      else passed++;
      step();
      idle();
      #1;
      total++;
      if (b2[0] !== 1'b0 || ab[0] !== 1'b0 || rd2[0] !== 32'hA5A5A5A5)
         $display("FAIL sb_clear b2=%b ab=%b rd2=%h want 0/0/a5a5a5a5",
                  b2[0], ab[0], rd2[0]);
      else passed++;
   endtask

   task automatic test_mark_write();
      do_reset();
      wr = 1'b1; wreg = 5'd3; wdata = 32'h0000_0042;
      mark = 1'b1; mreg = 5'd3;
      step();
      idle();
      rreg1 = 5'd3;
      #1;
      total++;
      if (rd1[0] !== 32'h42 || b1[0] !== 1'b1)
         $display("FAIL mw_same rd1=%h b1=%b want 42/1", rd1[0], b1[0]);
      else passed++;
      wr = 1'b1; wreg = 5'd3; wdata = 32'h7;
      mark = 1'b1; mreg = 5'd4;
      step();
      idle();
      rreg1 = 5'd3; rreg2 = 5'd4;
      #1;
      total++;
      if (b1[0] !== 1'b0 || b2[0] !== 1'b1 || rd1[0] !== 32'h7)
         $display("FAIL mw_diff b1=%b b2=%b rd1=%h want 0/1/7",
                  b1[0], b2[0], rd1[0]);
      else passed++;
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
      return 5'($urandom);
   endfunction

   task automatic test_random();
      logic [4:0]  a;
      logic [31:0] erd;
      bit          eb;
      do_reset();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 32; i++) begin
            m_regs[k][i] = 32'h0;
            m_busy[k][i] = 1'b0;
         end
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 39) != 0);
         wr    = ($urandom_range(0, 1) == 1);
         mark  = ($urandom_range(0, 2) == 0);
         wreg  = rnd_addr();
         mreg  = rnd_addr();
         rreg1 = rnd_addr();
         rreg2 = ($urandom_range(0, 3) == 0) ? rreg1 : rnd_addr();
         wdata = $urandom;
         #2;
         for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
               a   = (p == 0) ? rreg1 : rreg2;
               erd = exp_rd(k, a);
               eb  = (zr(k) && a == 0) ? 1'b0 : m_busy[k][a];
               total++;
               if (((p == 0) ? rd1[k] : rd2[k]) !== erd)
                  $display("FAIL rnd_rd n=%0d cfg=%0d port=%0d got=%h want=%h",
                           n, k, p + 1, (p == 0) ? rd1[k] : rd2[k], erd);
               else passed++;
               total++;
               if (((p == 0) ? b1[k] : b2[k]) !== eb)
                  $display("FAIL rnd_busy n=%0d cfg=%0d port=%0d got=%b want=%b",
                           n, k, p + 1, (p == 0) ? b1[k] : b2[k], eb);
               else passed++;
            end
            total++;
            if (ab[k] !== exp_any(k))
               $display("FAIL rnd_any n=%0d cfg=%0d got=%b want=%b",
                        n, k, ab[k], exp_any(k));
            else passed++;
         end
         model_edge();
         step();
      end
      idle();
      rst = 1'b1;
   endtask

   task automatic test_param_sweep();
      logic [15:0] v;
      do_reset();
      s_wr = 1'b1; s_wreg = 3'd7; s_wdata = 16'hBEEF;
      step();
      s_wr = 1'b0;
      s_r1 = 3'd7; s_r2 = 3'd7;
      #1;
      total++;
      if (s_rd1 !== 16'hBEEF || s_rd2 !== 16'hBEEF)
         $display("FAIL sw_beef rd1=%h rd2=%h want beef", s_rd1, s_rd2);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         s_wr = 1'b1; s_wreg = 3'(i); s_wdata = 16'(16'h1111 * (i + 1));
         step();
      end
      s_wr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_r1 = 3'(i); s_r2 = 3'(7 - i);
         #1;
         v = (i == 0) ? 16'h0 : 16'(16'h1111 * (i + 1));
         total++;
         if (s_rd1 !== v)
            $display("FAIL sw_reg%0d rd1=%h want=%h", i, s_rd1, v);
         else passed++;
      end
      for (int i = 1; i < 8; i++) begin
         s_mark = 1'b1; s_mreg = 3'(i);
         step();
         s_mark = 1'b0;
         #1;
         total++;
         if (s_ab !== 1'b1)
            $display("FAIL sw_any_set reg=%0d got=%b want=1", i, s_ab);
         else passed++;
         s_wr = 1'b1; s_wreg = 3'(i); s_wdata = 16'(i);
         step();
         s_wr = 1'b0;
         #1;
         total++;
         if (s_ab !== 1'b0)
            $display("FAIL sw_any_clr reg=%0d got=%b want=0", i, s_ab);
         else passed++;
      end
      s_mark = 1'b1; s_mreg = 3'd0;
      step();
      s_mark = 1'b0;
      #1;
      total++;
      if (s_ab !== 1'b0)
         $display("FAIL sw_zero_mark got=%b want=0", s_ab);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_zero_reg();
      test_scoreboard();
      test_mark_write();
      test_random();
      test_param_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor of the single-cycle core's 32x32 register file.
- Width and depth are generalised.
- Adds a hardwired-zero register 0, optional write-to-read bypass, and a per-register busy scoreboard. The scoreboard lets a future multi-cycle or pipelined core flag registers that still have a result in flight (loads, multi-cycle ALU ops).
- Sits between decode and execute: two combinational read ports, one synchronous write port, one busy-mark port.

Parameters:
- N, 32: data width in bits.
- AW, 5: register address width; DEPTH = 2**AW registers.
- BYPASS, 1: 1 = a same-cycle write to the read address is forwarded to RD; 0 = RD shows the stored value only.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, and never becomes busy; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- WR  in  1  write enable.
- WReg  in  AW  write address.
- WDATA  in  N  write data.
- RReg1  in  AW  read address, port 1.
- RReg2  in  AW  read address, port 2.
- RD1  out  N  read data, port 1 (combinational).
- RD2  out  N  read data, port 2 (combinational).
- MARK  in  1  set the busy bit of MReg.
- MReg  in  AW  register to mark busy.
- BUSY1  out  1  busy bit of RReg1 (combinational).
- BUSY2  out  1  busy bit of RReg2 (combinational).
- ANY_BUSY  out  1  OR of all busy bits (combinational).

Behaviour:
- Reset: on a rising clk edge with rst=0, every register is cleared to 0 and every busy bit is cleared, in that single cycle. WR and MARK are ignored in that cycle.
  - After that edge: RD1=RD2=0, BUSY1=BUSY2=ANY_BUSY=0 for any addresses.
  - Reset asserted mid-operation, including in the same cycle as WR or MARK: reset wins.
- Write:
  - With rst=1 and WR=1, regs[WReg] <= WDATA at the edge.
  - When ZERO_REG=1, a write with WReg==0 is discarded.
- Read:
  - RDx = regs[RRegx], purely combinational, zero latency.
  - When ZERO_REG=1 and RRegx==0, RDx = 0 regardless of any other input.
- Bypass (BYPASS=1): if WR=1, rst=1 and WReg==RRegx (and not the zero register when ZERO_REG=1), then RDx = WDATA in that same cycle. With BYPASS=0, the new value appears only after the edge.
- Scoreboard, busy[i] per register:
  - MARK=1 sets busy[MReg] at the edge.
  - WR=1 clears busy[WReg] at the edge; the result has arrived.
  - MARK and WR in the same cycle on different registers: both take effect.
  - MARK and WR in the same cycle on the same register: busy stays/becomes 1. The mark belongs to a newer producer and has priority over the clear. The data write still occurs.
  - When ZERO_REG=1: MARK on register 0 is ignored, and BUSY for address 0 is always 0.
  - BUSYx = busy[RRegx]. There is no bypass on busy: a clearing write in the current cycle is visible only after the edge.
- Both read ports may address the same register; each port is evaluated independently.
- Addresses wrap naturally within AW bits; there are no out-of-range addresses.
- Writes with WR=0 leave all state unchanged. Outputs carry no X after the first reset edge.

Test Plan:
- Reset clear: write 32'h12345678 to reg 7, mark reg 9, then pulse rst=0 for one cycle → RD1(RReg1=7)=0, BUSY for reg 9 = 0, ANY_BUSY=0.
- Write/read with bypass: BYPASS=1, WR=1, WReg=5, WDATA=32'hDEADBEEF, RReg1=5 → RD1=32'hDEADBEEF in the same cycle. Repeat with BYPASS=0 → RD1=0 before the edge and 32'hDEADBEEF after it.
- Zero register: ZERO_REG=1, write 32'hCAFEBABE to reg 0 and MARK reg 0 → RD1=0 and BUSY1=0 both before and after the edge.
- Scoreboard lifecycle: MARK reg 10 → BUSY2(RReg2=10)=1 and ANY_BUSY=1 next cycle; then WR reg 10 with 32'hA5A5A5A5 → BUSY2=0 and RD2=32'hA5A5A5A5 after the edge.
- Simultaneous mark and write on reg 3 (WDATA=32'h0000_0042) → regs[3]=32'h42 and BUSY1(RReg1=3)=1 after the edge. Simultaneous mark reg 4 with write reg 3 → busy[4]=1, busy[3]=0.
- Parameter sweep: N=16, AW=3 → write 16'hBEEF to reg 7, read it back on both ports, confirm 8 registers and that ANY_BUSY works across all of them.
